// File: rtl/quick_spi.sv
// quick_spi: single-domain SPI master with write and read-after-command modes.
// SCLK runs at clk/2; CPOL/CPHA select idle level and sampling edge.
module quick_spi #(
    parameter int INCOMING_DATA_WIDTH = 8,
    parameter int OUTGOING_DATA_WIDTH = 16,
    parameter int CPOL = 0,
    parameter int CPHA = 0
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           enable,
    input  logic                           start_transaction,
    input  logic [1:0]                     slave,
    input  logic                           operation,
    output logic                           end_of_transaction,
    output logic [INCOMING_DATA_WIDTH-1:0] incoming_data,
    input  logic [OUTGOING_DATA_WIDTH-1:0] outgoing_data,
    output logic                           mosi,
    input  logic                           miso,
    output logic                           sclk,
    output logic [1:0]                     ss_n
);

    localparam int RD_BITS = 8 + INCOMING_DATA_WIDTH;
    localparam int TX_W = (OUTGOING_DATA_WIDTH > RD_BITS) ?
                          OUTGOING_DATA_WIDTH : RD_BITS;
    localparam int CW = $clog2(2 * TX_W) + 1;
    localparam logic IDLE_LVL = 1'(CPOL);
    localparam logic PHA = 1'(CPHA);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_END
    } state_t;

    state_t state, state_next;

    logic                           op_q;
    logic [1:0]                     slave_q;
    logic [TX_W-1:0]                sh;
    logic [TX_W-1:0]                tx_load;
    logic [INCOMING_DATA_WIDTH-1:0] rx;
    logic [INCOMING_DATA_WIDTH-1:0] rx_next;
    logic [CW-1:0]                  cnt;
    logic [CW-1:0]                  last_cnt;
    logic                           last;
    logic                           capture;
    logic                           advance;
    logic                           go;

    assign go = enable && start_transaction;

    // Left-aligned transmit image: full word for writes, command byte for reads.
    always_comb begin
        tx_load = '0;
        if (operation)
            tx_load[TX_W-1 -: OUTGOING_DATA_WIDTH] = outgoing_data;
        else
            tx_load[TX_W-1 -: 8] = outgoing_data[OUTGOING_DATA_WIDTH-1 -: 8];
    end

    // Half-period bookkeeping: even cnt = first half of a bit, odd = second.
    always_comb begin
        last_cnt = op_q ? CW'(2 * OUTGOING_DATA_WIDTH - 1) : CW'(2 * RD_BITS - 1);
        last     = (cnt == last_cnt);
        capture  = !op_q && (cnt >= CW'(16)) && (cnt[0] == PHA);
        advance  = (cnt[0] == ~PHA);
        rx_next  = capture ? ((rx << 1) | INCOMING_DATA_WIDTH'(miso)) : rx;
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    // Next-state logic; dropping enable aborts an active transfer.
    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:   if (go) state_next = S_ACTIVE;
            S_ACTIVE: begin
                if (!enable)
                    state_next = S_IDLE;
                else if (last)
                    state_next = S_END;
            end
            S_END:    state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Decoded outputs: selects only while active, pulse during END.
    always_comb begin
        ss_n               = (state == S_ACTIVE) ? ~slave_q : 2'b11;
        end_of_transaction = (state == S_END);
    end

    // Shift datapath, SCLK generation and read result capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q          <= 1'b0;
            slave_q       <= 2'b00;
            sh            <= '0;
            rx            <= '0;
            cnt           <= '0;
            mosi          <= 1'b0;
            sclk          <= IDLE_LVL;
            incoming_data <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    sclk <= IDLE_LVL;
                    cnt  <= '0;
                    if (go) begin
                        op_q    <= operation;
                        slave_q <= slave;
                        rx      <= '0;
                        if (PHA) begin
                            sh   <= tx_load;
                            mosi <= 1'b0;
                        end else begin
                            sh   <= tx_load << 1;
                            mosi <= tx_load[TX_W-1];
                        end
                    end else begin
                        mosi <= 1'b0;
                    end
                end
                S_ACTIVE: begin
                    if (!enable || last) begin
                        sclk <= IDLE_LVL;
                        mosi <= 1'b0;
                        cnt  <= '0;
                        if (enable && !op_q)
                            incoming_data <= rx_next;
                    end else begin
                        cnt  <= cnt + 1'b1;
                        sclk <= cnt[0] ? IDLE_LVL : ~IDLE_LVL;
                        rx   <= rx_next;
                        if (advance) begin
                            mosi <= sh[TX_W-1];
                            sh   <= sh << 1;
                        end
                    end
                end
                default: begin
                    sclk <= IDLE_LVL;
                    mosi <= 1'b0;
                    cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quick_spi.sv
// tb_quick_spi: directed bench for quick_spi in mode CPOL=0, CPHA=0.
// Each step drives inputs after a clock edge and checks outputs 1ns later.
module tb_quick_spi;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        start_transaction;
    logic [1:0]  slave;
    logic        operation;
    logic        end_of_transaction;
    logic [7:0]  incoming_data;
    logic [15:0] outgoing_data;
    logic        mosi;
    logic        miso;
    logic        sclk;
    logic [1:0]  ss_n;

    int checks = 0;
    int errors = 0;

    logic [15:0] bits;
    int          eot_k;
    int          eot_n;
    int          ss_bad;
    logic [7:0]  inc_eot;

    quick_spi dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .enable             (enable),
        .start_transaction  (start_transaction),
        .slave              (slave),
        .operation          (operation),
        .end_of_transaction (end_of_transaction),
        .incoming_data      (incoming_data),
        .outgoing_data      (outgoing_data),
        .mosi               (mosi),
        .miso               (miso),
        .sclk               (sclk),
        .ss_n               (ss_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Run one transaction from IDLE; optionally disturb inputs at chg_at.
    task automatic run(input logic [1:0] exp_ss, input int chg_at);
        bits    = '0;
        eot_k   = -1;
        eot_n   = 0;
        ss_bad  = 0;
        inc_eot = 'x;
        tick();
        for (int k = 0; k < 40; k++) begin
            if (k < 32 && sclk === 1'b1)
                bits = {bits[14:0], mosi};
            if (k < 32 && ss_n !== exp_ss)
                ss_bad++;
            if (end_of_transaction === 1'b1) begin
                eot_n++;
                eot_k   = k;
                inc_eot = incoming_data;
            end
            if (k == 0)
                start_transaction = 1'b0;
            if (k == chg_at) begin
                outgoing_data = ~outgoing_data;
                slave         = ~slave;
            end
            tick();
        end
    endtask

    initial begin
        int         gap;
        int         gaps[$];
        int         sclk_bad;
        int         eots;
        logic [7:0] inc_first;
        logic [7:0] inc_second;
        logic       psclk;
        logic [1:0] pss;

        reset_n           = 1'b0;
        enable            = 1'b0;
        start_transaction = 1'b0;
        slave             = 2'b00;
        operation         = 1'b0;
        outgoing_data     = '0;
        miso              = 1'b0;
        tick();
        tick();
        chk("rst_ss_n", 32'(ss_n), 32'h3);
        chk("rst_sclk", 32'(sclk), 32'h0);
        chk("rst_mosi", 32'(mosi), 32'h0);
        chk("rst_eot", 32'(end_of_transaction), 32'h0);
        chk("rst_inc", 32'(incoming_data), 32'h0);

        reset_n = 1'b1;
        tick();
        chk("idle_ss_n", 32'(ss_n), 32'h3);

        enable = 1'b1;
        start_transaction = 1'b1;
        operation = 1'b1;
        slave = 2'b01;
        outgoing_data = 16'h5A5A;
        run(2'b10, -1);
        chk("wr_bits", 32'(bits), 32'h5A5A);
        chk("wr_ss", 32'(ss_bad), 32'h0);
        chk("wr_eot_k", 32'(eot_k), 32'd32);
        chk("wr_eot_n", 32'(eot_n), 32'd1);
        chk("wr_inc", 32'(inc_eot), 32'h00);
        chk("wr_mosi_end", 32'(mosi), 32'h0);

        start_transaction = 1'b1;
        operation = 1'b0;
        miso = 1'b1;
        run(2'b10, -1);
        chk("rd_bits", 32'(bits), 32'h5A00);
        chk("rd_eot_k", 32'(eot_k), 32'd32);
        chk("rd_eot_n", 32'(eot_n), 32'd1);
        chk("rd_inc", 32'(inc_eot), 32'hFF);

        start_transaction = 1'b1;
        slave = 2'b00;
        miso = 1'b0;
        outgoing_data = 16'hC3FF;
        run(2'b11, -1);
        chk("nosel_bits", 32'(bits), 32'hC300);
        chk("nosel_ss", 32'(ss_bad), 32'h0);
        chk("nosel_eot_k", 32'(eot_k), 32'd32);
        chk("nosel_inc", 32'(incoming_data), 32'h00);

        slave = 2'b01;
        operation = 1'b1;
        miso = 1'b1;
        outgoing_data = 16'h5A5A;
        start_transaction = 1'b1;
        gap = 0;
        sclk_bad = 0;
        eots = 0;
        inc_first = 'x;
        inc_second = 'x;
        tick();
        psclk = sclk;
        pss = ss_n;
        for (int k = 0; k < 100; k++) begin
            if (ss_n === 2'b11) begin
                gap++;
                if (pss === 2'b11 && sclk !== psclk)
                    sclk_bad++;
            end else begin
                if (gap > 0)
                    gaps.push_back(gap);
                gap = 0;
            end
            if (end_of_transaction === 1'b1) begin
                eots++;
                if (eots == 1) inc_first = incoming_data;
                if (eots == 2) inc_second = incoming_data;
                operation = ~operation;
            end
            psclk = sclk;
            pss = ss_n;
            tick();
        end
        start_transaction = 1'b0;
        chk("b2b_eots", 32'(eots), 32'd2);
        chk("b2b_ngaps", 32'(gaps.size()), 32'd2);
        if (gaps.size() == 2) begin
            chk("b2b_gap0", 32'(gaps[0]), 32'd2);
            chk("b2b_gap1", 32'(gaps[1]), 32'd2);
        end
        chk("b2b_sclk", 32'(sclk_bad), 32'h0);
        chk("b2b_wr_inc", 32'(inc_first), 32'h00);
        chk("b2b_rd_inc", 32'(inc_second), 32'hFF);
        for (int i = 0; i < 10; i++)
            tick();
        chk("b2b_idle_ss", 32'(ss_n), 32'h3);

        operation = 1'b0;
        miso = 1'b0;
        slave = 2'b10;
        start_transaction = 1'b1;
        tick();
        start_transaction = 1'b0;
        for (int i = 0; i < 10; i++)
            tick();
        chk("ab_ss_act", 32'(ss_n), 32'h1);
        enable = 1'b0;
        tick();
        chk("ab_ss_n", 32'(ss_n), 32'h3);
        chk("ab_sclk", 32'(sclk), 32'h0);
        chk("ab_mosi", 32'(mosi), 32'h0);
        eots = 0;
        for (int i = 0; i < 30; i++) begin
            if (end_of_transaction === 1'b1)
                eots++;
            tick();
        end
        chk("ab_no_eot", 32'(eots), 32'h0);
        chk("ab_inc", 32'(incoming_data), 32'hFF);

        enable = 1'b1;
        operation = 1'b1;
        outgoing_data = 16'hA5C3;
        start_transaction = 1'b1;
        run(2'b01, -1);
        chk("re_bits", 32'(bits), 32'hA5C3);
        chk("re_ss", 32'(ss_bad), 32'h0);
        chk("re_eot_k", 32'(eot_k), 32'd32);

        slave = 2'b01;
        outgoing_data = 16'h3C96;
        start_transaction = 1'b1;
        run(2'b10, 3);
        chk("stab_bits", 32'(bits), 32'h3C96);
        chk("stab_ss", 32'(ss_bad), 32'h0);
        chk("stab_eot_n", 32'(eot_n), 32'd1);

        operation = 1'b0;
        miso = 1'b1;
        start_transaction = 1'b1;
        tick();
        start_transaction = 1'b0;
        for (int i = 0; i < 21; i++)
            tick();
        chk("mr_sclk_hi", 32'(sclk), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("mr_ss_n", 32'(ss_n), 32'h3);
        chk("mr_sclk", 32'(sclk), 32'h0);
        chk("mr_mosi", 32'(mosi), 32'h0);
        chk("mr_eot", 32'(end_of_transaction), 32'h0);
        chk("mr_inc", 32'(incoming_data), 32'h00);
        tick();
        reset_n = 1'b1;
        eots = 0;
        ss_bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (end_of_transaction === 1'b1)
                eots++;
            if (ss_n !== 2'b11)
                ss_bad++;
            tick();
        end
        chk("mr_no_eot", 32'(eots), 32'h0);
        chk("mr_no_sel", 32'(ss_bad), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/quick_spi.md
QUICK_SPI -- requirements
Module: quick_spi

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter INCOMING_DATA_WIDTH, default 8, giving the bits received per read transaction.
REQ-002 The block SHALL have parameter OUTGOING_DATA_WIDTH, default 16, giving the bits of the outgoing buffer.
REQ-003 The block SHALL have parameter CPOL, default 0, giving the SCLK idle level.
REQ-004 The block SHALL have parameter CPHA, default 0; 0 samples on the leading SCLK edge, 1 samples on the trailing edge.
Ports (name, direction, width, meaning):
REQ-005 The ports SHALL be as follows; one clock domain; reset is asynchronous and active-low.
- clk, input, 1: system clock.
- reset_n, input, 1: asynchronous active-low reset.
- enable, input, 1: block enable.
- start_transaction, input, 1: transaction request, level-sensitive.
- slave, input, 2: slave select mask, 1 = selected.
- operation, input, 1: 1 = write, 0 = read.
- end_of_transaction, output, 1: one-clk completion pulse.
- incoming_data, output, INCOMING_DATA_WIDTH: last read result.
- outgoing_data, input, OUTGOING_DATA_WIDTH: data to transmit, MSB first.
- mosi, output, 1: serial data out.
- miso, input, 1: serial data in.
- sclk, output, 1: SPI clock.
- ss_n, output, 2: active-low slave selects.

Function
REQ-006 States SHALL be IDLE, ACTIVE and END.
REQ-007 IDLE -> ACTIVE SHALL occur on a clk edge where enable=1 and start_transaction=1.
- At that edge, latch operation, slave and outgoing_data.
- Later changes to these inputs SHALL NOT affect the running transaction.
REQ-008 ss_n SHALL equal ~latched_slave in ACTIVE and 2'b11 in IDLE and END.
REQ-009 A bit period SHALL be 2 clk cycles: sclk at CPOL for one cycle, then at ~CPOL for one cycle (sclk frequency = clk/2).
REQ-010 Bit transmission for CPHA=0:
- mosi holds the current bit from ACTIVE entry.
- miso is sampled at the leading sclk edge.
- mosi advances at the trailing edge.
REQ-011 For CPHA=1, mosi SHALL change at the leading edge and miso SHALL be sampled at the trailing edge.
REQ-012 Write (operation=1): shift out all OUTGOING_DATA_WIDTH bits, MSB first (16 bit periods = 32 clk); miso ignored; incoming_data unchanged.
REQ-013 Read (operation=0):
- Shift out outgoing_data[MSB -: 8] (8 bit periods).
- Then capture INCOMING_DATA_WIDTH bits from miso, MSB first, with mosi held 0.
- Default total: 16 bit periods = 32 clk.
REQ-014 After the last bit period, sclk SHALL return to CPOL and the state SHALL go to END for exactly one clk.
REQ-015 In END:
- end_of_transaction = 1 for that single cycle.
- For reads, incoming_data updates at the same edge that asserts end_of_transaction.
REQ-016 END SHALL always go to IDLE; ss_n stays high for at least 2 clk between back-to-back transactions.
REQ-017 With start_transaction and enable held high, the next transaction SHALL start at the first IDLE cycle (start sampled 33 clk after the previous start, ACTIVE 34 clk after).
REQ-018 If enable=0 during ACTIVE, the block SHALL abort at the next edge:
- Go to IDLE with ss_n=2'b11, sclk=CPOL, mosi=0.
- No end_of_transaction pulse; incoming_data unchanged.
REQ-019 In IDLE, mosi SHALL be 0 and sclk SHALL be CPOL.
REQ-020 slave=2'b00 SHALL still run a full transaction with ss_n=2'b11 throughout.

Reset
REQ-021 reset_n=0 SHALL immediately force:
- state IDLE, sclk=CPOL, mosi=0, ss_n=2'b11;
- end_of_transaction=0, incoming_data=0;
- shift registers and bit counter cleared.
REQ-022 Reset asserted mid-transaction SHALL abort it with no end_of_transaction pulse; operation resumes only on a new start after reset_n=1.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Write basic: reset, enable=1, start=1, operation=1, slave=2'b01, outgoing_data=16'h5A5A -> ss_n=2'b10; mosi at the 16 rising sclk edges = 0101101001011010; end_of_transaction pulses one clk, 32 clk after ACTIVE entry; incoming_data stays 0.
- Read with miso=1: operation=0, outgoing_data=16'h5A5A -> first 8 mosi bits 01011010, then mosi=0; incoming_data=8'hFF at the end_of_transaction pulse.
- Back-to-back: start held high, operation toggled on each end_of_transaction -> alternating write/read; ss_n high exactly 2 clk between them; sclk never toggles while ss_n high.
- Mid-transaction abort: enable=0 after 10 clk in ACTIVE -> next edge ss_n=2'b11, sclk=0, no end pulse; re-enable -> a fresh full transaction.
- Mid-transaction reset: reset_n=0 mid-read -> outputs reach reset values asynchronously; incoming_data=0.
- Input stability: change outgoing_data and slave during ACTIVE -> transmitted bits and ss_n keep the values latched at start.
